// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pooling scheduler.
//   POOL_DATA_WIDTH : default element width (Q8.8 signed)
//   pool_state_t    : scheduler FSM states
//   clog2           : ceiling log2, never less than 1 so derived widths stay legal
package pool_pkg;

  localparam int POOL_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } pool_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of four elements, built as two compare stages.
//   in0..in3 : signed operands
//   y        : largest operand (ties are value-identical, so order is irrelevant)
module pool_max4 import pool_pkg::*; #(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] in0,
  input  logic signed [DATA_WIDTH-1:0] in1,
  input  logic signed [DATA_WIDTH-1:0] in2,
  input  logic signed [DATA_WIDTH-1:0] in3,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] max01;
  logic signed [DATA_WIDTH-1:0] max23;

  assign max01 = (in0 > in1) ? in0 : in1;
  assign max23 = (in2 > in3) ? in2 : in3;
  assign y     = (max01 > max23) ? max01 : max23;

endmodule

// File: rtl/pool_scheduler.sv
// Sequences 2x2/stride-2 max-pooling over a multi-channel feature map.
// Each window: four single-word reads (FETCH), last data beat (WAIT),
// then the pooled value is presented on a valid/ready port (EMIT).
//   clk, reset          : clock, asynchronous active-high reset
//   start, busy, done   : run handshake (start sampled only in IDLE)
//   rd_en, rd_addr      : read request to input buffer
//   rd_data             : read data, one cycle after rd_en
//   out_valid/out_ready : output handshake
//   out_data, out_addr  : pooled value and its output-buffer address
module pool_scheduler import pool_pkg::*; #(
  parameter  int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter  int IN_SIZE    = 256,
  parameter  int CHANNELS   = 64,
  localparam int IN_AW      = clog2(CHANNELS * IN_SIZE * IN_SIZE),
  localparam int OUT_AW     = clog2(CHANNELS * (IN_SIZE / 2) * (IN_SIZE / 2))
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [IN_AW-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OUT_AW-1:0]     out_addr
);

  localparam int HALF = IN_SIZE / 2;
  localparam int CW   = clog2(CHANNELS);
  localparam int SW   = clog2(IN_SIZE);

  pool_state_t state, state_nx;

  logic [CW-1:0] c;
  logic [SW-1:0] r;
  logic [SW-1:0] col;
  logic [1:0]    k;

  // Only three window elements are stored; the fourth is still on rd_data
  // during WAIT and feeds the comparator directly.
  logic signed [DATA_WIDTH-1:0] w [3];
  logic signed [DATA_WIDTH-1:0] max_val;

  logic last_col, last_row, last_ch, last_win;

  assign last_col = (col == SW'(IN_SIZE - 2));
  assign last_row = (r == SW'(IN_SIZE - 2));
  assign last_ch  = (c == CW'(CHANNELS - 1));
  assign last_win = last_col && last_row && last_ch;

  // k[1] selects the lower row of the window, k[0] the right column.
  assign rd_addr = IN_AW'(32'(c) * IN_SIZE * IN_SIZE
                        + (32'(r) + 32'(k[1])) * IN_SIZE
                        + 32'(col) + 32'(k[0]));

  pool_max4 #(.DATA_WIDTH(DATA_WIDTH)) u_max4 (
    .in0 (w[0]),
    .in1 (w[1]),
    .in2 (w[2]),
    .in3 (rd_data),
    .y   (max_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (k == 2'd3) state_nx = WAIT;
      WAIT:    state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = last_win ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      FETCH: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      WAIT:  busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c        <= '0;
      r        <= '0;
      col      <= '0;
      k        <= '0;
      out_data <= '0;
      out_addr <= '0;
      for (int i = 0; i < 3; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c   <= '0;
            r   <= '0;
            col <= '0;
            k   <= '0;
          end
        end
        FETCH: begin
          k <= k + 2'd1;
          if (k != 2'd0) w[k - 2'd1] <= rd_data;
        end
        WAIT: begin
          out_data <= max_val;
          out_addr <= OUT_AW'(32'(c) * HALF * HALF
                            + 32'(r >> 1) * HALF
                            + 32'(col >> 1));
        end
        EMIT: begin
          if (out_ready) begin
            k <= '0;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                r <= '0;
                c <= last_ch ? '0 : c + CW'(1);
              end else begin
                r <= r + SW'(2);
              end
            end else begin
              col <= col + SW'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
